// File: rtl/hazard_detection_unit.sv
// Load-use stall and taken-branch flush controller for the 5-stage pipeline.
// Control outputs are combinational; stall/flush event counters are registered.
module hazard_detection_unit #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs1,
    input  logic [4:0]       ID_Rs2,
    input  logic             ID_UsesRs1,
    input  logic             ID_UsesRs2,
    input  logic [4:0]       EX_Rd,
    input  logic             EX_MemRead,
    input  logic             EX_BranchTaken,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             Stall_Active,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    typedef enum logic {StRun, StStall} state_t;

    // Bubbles still owed after the hazard cycle itself.
    localparam logic [3:0] StallRem = 4'(LOAD_STALL_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_d;
    logic [3:0]       r_rem;
    logic [3:0]       w_rem_d;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_hz;
    logic             w_stall_inc;
    logic             w_flush_inc;

    assign w_hz = EX_MemRead && (EX_Rd != 5'd0) &&
                  ((ID_UsesRs1 && (ID_Rs1 == EX_Rd)) || (ID_UsesRs2 && (ID_Rs2 == EX_Rd)));

    always_comb begin
        PC_Write     = 1'b1;
        IFID_Write   = 1'b1;
        IDEX_Bubble  = 1'b0;
        IFID_Flush   = 1'b0;
        IDEX_Flush   = 1'b0;
        Stall_Active = 1'b0;
        w_state_d    = r_state;
        w_rem_d      = r_rem;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;

        if (reset) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else begin
            case (r_state)
                StRun: begin
                    if (EX_BranchTaken) begin
                        // The ID instruction is squashed, so a coincident hazard is moot.
                        IFID_Flush  = 1'b1;
                        IDEX_Flush  = 1'b1;
                        w_flush_inc = 1'b1;
                    end else if (w_hz) begin
                        PC_Write     = 1'b0;
                        IFID_Write   = 1'b0;
                        IDEX_Bubble  = 1'b1;
                        Stall_Active = 1'b1;
                        w_stall_inc  = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            w_state_d = StStall;
                            w_rem_d   = StallRem;
                        end
                    end
                end
                StStall: begin
                    if (EX_BranchTaken) begin
                        IFID_Flush  = 1'b1;
                        IDEX_Flush  = 1'b1;
                        w_flush_inc = 1'b1;
                        w_state_d   = StRun;
                        w_rem_d     = 4'd0;
                    end else begin
                        PC_Write     = 1'b0;
                        IFID_Write   = 1'b0;
                        IDEX_Bubble  = 1'b1;
                        Stall_Active = 1'b1;
                        w_stall_inc  = 1'b1;
                        w_rem_d      = r_rem - 4'd1;
                        if (r_rem <= 4'd1) begin
                            w_state_d = StRun;
                            w_rem_d   = 4'd0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StRun;
            r_rem       <= 4'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            r_rem   <= w_rem_d;
            if (w_stall_inc) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush_inc) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign Stall_Count = r_stall_cnt;
    assign Flush_Count = r_flush_cnt;

endmodule
